// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and parameter defaults.
`timescale 1ns/1ps
package pll_seq_pkg;

    localparam int SYNC_STAGES_DEFAULT   = 2;
    localparam int STABLE_CYCLES_DEFAULT = 1024;
    localparam int TICK_DIV_DEFAULT      = 250;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } SeqState;

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL lock flag into the refclk domain.
`timescale 1ns/1ps
module pll_lock_sync
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic i_refclk,
    input  logic i_rst,
    input  logic i_locked,
    output logic o_lockedS
);

    logic [SYNC_STAGES-1:0] r_syncChain;

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_syncChain <= '0;
        end else begin
            r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], i_locked};
        end
    end

    assign o_lockedS = r_syncChain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock over a stable window, then releases downstream reset and runs a 1 MHz tick.
`timescale 1ns/1ps
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int TICK_DIV      = TICK_DIV_DEFAULT
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       sys_rst,
    output logic       ready,
    output logic       tick,
    output logic [7:0] lock_loss_cnt,
    output logic [1:0] state_o
);

    localparam int STABLE_W = $clog2(STABLE_CYCLES);
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_DIV - 1);

    SeqState             r_state;
    SeqState             w_nextState;
    logic [STABLE_W-1:0] r_stableCnt;
    logic [TICK_W-1:0]   r_tickCnt;
    logic [7:0]          r_lossCnt;
    logic                r_sysRst;
    logic                r_ready;
    logic                r_tick;
    logic                w_lockedS;
    logic                w_tickWrap;

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lockSync (
        .i_refclk  (refclk),
        .i_rst     (rst),
        .i_locked  (locked),
        .o_lockedS (w_lockedS)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            WAIT_LOCK: if (w_lockedS) w_nextState = STABLE;
            STABLE: begin
                if (!w_lockedS) begin
                    w_nextState = WAIT_LOCK;
                end else if (r_stableCnt == STABLE_LAST) begin
                    w_nextState = RUN;
                end
            end
            RUN:     if (!w_lockedS) w_nextState = LOST;
            LOST:    w_nextState = WAIT_LOCK;
            default: w_nextState = WAIT_LOCK;
        endcase
    end

    assign w_tickWrap = (r_state == RUN) && (r_tickCnt == TICK_LAST);

    // Outputs are computed from the next state so they line up with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state     <= WAIT_LOCK;
            r_stableCnt <= '0;
            r_tickCnt   <= '0;
            r_lossCnt   <= '0;
            r_sysRst    <= 1'b1;
            r_ready     <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_stableCnt <= ((r_state == STABLE) && (w_nextState == STABLE)) ? r_stableCnt + 1'b1 : '0;
            r_tickCnt   <= (r_state != RUN) ? '0 : (w_tickWrap ? '0 : r_tickCnt + 1'b1);
            r_tick      <= w_tickWrap && (w_nextState == RUN);
            r_sysRst    <= (w_nextState != RUN);
            r_ready     <= (w_nextState == RUN);
            if ((w_nextState == LOST) && (r_lossCnt != 8'hFF)) begin
                r_lossCnt <= r_lossCnt + 8'd1;
            end
        end
    end

    assign sys_rst       = r_sysRst;
    assign ready         = r_ready;
    assign tick          = r_tick;
    assign lock_loss_cnt = r_lossCnt;
    assign state_o       = r_state;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the synchroniser chain for `locked`; minimum 2.
REQ-002 Parameter STABLE_CYCLES, default 1024: consecutive synchronised-lock cycles required before reset release; minimum 2.
REQ-003 Parameter TICK_DIV, default 250: refclk cycles per `tick` pulse (1 MHz at 250 MHz); minimum 2.
REQ-004 refclk  input  1  the block's single clock, 250 MHz, driven by PLL outclk_0.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the refclk rising edge.
REQ-006 locked  input  1  PLL lock indicator, asynchronous to refclk.
REQ-007 sys_rst  output  1  active-high synchronous reset for downstream logic.
REQ-008 ready  output  1  high only in RUN.
REQ-009 tick  output  1  single-cycle clock-enable strobe, every TICK_DIV cycles, only in RUN.
REQ-010 lock_loss_cnt  output  8  saturating count of lock losses that occurred in RUN.
REQ-011 state_o  output  2  current FSM state encoding, for debug.

Function
REQ-012 `locked` SHALL pass through SYNC_STAGES flops; the last stage is `locked_s`, and no other logic SHALL read `locked`.
REQ-013 The FSM SHALL have four states: WAIT_LOCK=0, STABLE=1, RUN=2, LOST=3.
REQ-014 WAIT_LOCK: stable counter held at 0; go to STABLE on the next edge when locked_s=1.
REQ-015 STABLE: stable counter increments each cycle; locked_s=0 -> WAIT_LOCK with no change to lock_loss_cnt; counter==STABLE_CYCLES-1 with locked_s=1 -> RUN.
REQ-016 RUN: locked_s=0 -> LOST on the next edge.
REQ-017 LOST: lasts exactly one cycle, then WAIT_LOCK unconditionally; lock_loss_cnt increments by 1 on entry, saturating at 255.
REQ-018 All outputs SHALL be registered. sys_rst = 0 and ready = 1 exactly when the state register is RUN; otherwise sys_rst = 1 and ready = 0.
REQ-019 Latency: with locked held high, sys_rst SHALL fall on the edge that is SYNC_STAGES+STABLE_CYCLES edges after the first edge that samples locked=1.
REQ-020 Tick counter: 0..TICK_DIV-1, cleared whenever the state is not RUN. tick=1 for one cycle when the counter wraps; the first tick occurs TICK_DIV cycles after RUN entry.
REQ-021 Lock loss in RUN: sys_rst SHALL re-assert, and ready and tick SHALL drop, on the edge entering LOST, i.e. SYNC_STAGES+1 edges after locked falls.
REQ-022 A locked glitch shorter than one refclk period that is not captured SHALL have no effect. A captured glitch SHALL be treated as a real event.

Reset
REQ-023 rst=1 SHALL force, on the same edge: state WAIT_LOCK, synchroniser flops 0, stable and tick counters 0, lock_loss_cnt 0, sys_rst 1, ready 0, tick 0.
REQ-024 rst asserted mid-STABLE or mid-RUN SHALL abort immediately with no lock_loss_cnt increment. After rst falls, the full SYNC_STAGES+STABLE_CYCLES qualification SHALL restart.
REQ-025 If rst and a lock loss occur in the same cycle, rst SHALL win.

Structure
REQ-026 A shared package pll_seq_pkg SHALL hold the state enum (2-bit) and the default values of SYNC_STAGES, STABLE_CYCLES and TICK_DIV.
REQ-027 The synchroniser SHALL be a sub-module pll_lock_sync, parameterised by SYNC_STAGES, with synchronous reset to 0. All other logic lives in pll_reset_sequencer.
REQ-028 Counter widths SHALL be $clog2 of the respective parameter.

Verification (bench parameters: SYNC_STAGES=2, STABLE_CYCLES=16, TICK_DIV=5)
REQ-029 Release: rst low, locked rises at edge 0 and stays high -> sys_rst falls at edge 18, ready=1, first tick at edge 23, then every 5 cycles.
REQ-030 Premature drop: locked high for 10 cycles, then low, then high -> lock_loss_cnt stays 0, state returns to WAIT_LOCK, and the 16-cycle count restarts from 0.
REQ-031 Loss in RUN: locked falls -> sys_rst=1, ready=0, tick=0 three edges later; lock_loss_cnt=1; state sequence LOST then WAIT_LOCK; re-release 18 edges after locked returns.
REQ-032 Saturation: 260 loss/relock cycles -> lock_loss_cnt reads 255 and never wraps.
REQ-033 Reset mid-RUN: rst pulsed for 1 cycle with locked high -> all outputs return to reset values on that edge, lock_loss_cnt=0, sys_rst re-falls 18 edges after rst falls.
REQ-034 Simultaneous events: rst=1 in the same cycle that locked_s falls in RUN -> state WAIT_LOCK and lock_loss_cnt=0, with no LOST state observed.
